// File: rtl/jtframe_led_pkg.sv
// rtl/jtframe_led_pkg.sv - shared types and constants for the LED blink-code block
// Holds the sequencer state encoding, frame-counter width and default timings.
package jtframe_led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2,
    ST_PAUSE = 2'd3
  } led_state_e;

  localparam int FCNT_W             = 8;
  localparam int DEF_ON_FRAMES      = 8;
  localparam int DEF_OFF_FRAMES     = 8;
  localparam int DEF_PAUSE_FRAMES   = 32;
  localparam int DEF_REPEAT         = 2;

  // A repeat count of zero still plays the group once.
  function automatic int rep_target(input int r);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/jtframe_led_frmcnt.sv
// rtl/jtframe_led_frmcnt.sv - LVBL frame strobe and per-state frame counter
// done_o fires on the strobe that completes len_i frames; clr_i holds the count at zero.
module jtframe_led_frmcnt
  import jtframe_led_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lvbl_i,
  input  logic              clr_i,
  input  logic [FCNT_W-1:0] len_i,
  output logic              done_o
);

  logic              last_lvbl_q;
  logic              fs_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lvbl_q <= 1'b1;
      fs_q        <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      last_lvbl_q <= lvbl_i;
      fs_q        <= last_lvbl_q & ~lvbl_i;
      fcnt_q      <= fcnt_d;
    end
  end

  assign done_o = fs_q && (fcnt_q == (len_i - 1'b1));

  always_comb begin
    fcnt_d = fcnt_q;
    if (clr_i || done_o) begin
      fcnt_d = '0;
    end else if (fs_q) begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_led_pattern.sv
// rtl/jtframe_led_pattern.sv - LED pass-through with frame-timed blink-code override
// Optional JTFRAME_LED_PWM_EN adds a dim input that PWM-modulates every lit period.
module jtframe_led_pattern
  import jtframe_led_pkg::*;
#(
  parameter int   ON_FRAMES    = DEF_ON_FRAMES,
  parameter int   OFF_FRAMES   = DEF_OFF_FRAMES,
  parameter int   PAUSE_FRAMES = DEF_PAUSE_FRAMES,
  parameter int   REPEAT       = DEF_REPEAT,
  parameter logic POL          = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LVBL,
  input  logic       led_in,
  input  logic [2:0] code,
  input  logic       code_valid,
`ifdef JTFRAME_LED_PWM_EN
  input  logic [3:0] dim,
`endif
  output logic       code_ready,
  output logic       busy,
  output logic       led_out
);

  localparam int REP_N = rep_target(REPEAT);
  localparam int REP_W = ($clog2(REPEAT + 1) < 1) ? 1 : $clog2(REPEAT + 1);

  led_state_e        state_q, state_d;
  logic [2:0]        blk_cnt_q, blk_cnt_d;
  logic [2:0]        blk_tgt_q, blk_tgt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              led_out_q, led_out_d;
  logic              busy_q, busy_d;
  logic              code_ready_q, code_ready_d;
  logic              fdone;
  logic              fclr;
  logic              accept;
  logic              lit_ok;
  logic [FCNT_W-1:0] frame_len;

`ifdef JTFRAME_LED_PWM_EN
  logic [3:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_q + 1'b1;
  end

  assign lit_ok = (pwm_cnt_q <= dim);
`else
  assign lit_ok = 1'b1;
`endif

  always_comb begin
    frame_len = FCNT_W'(ON_FRAMES);
    case (state_q)
      ST_OFF:   frame_len = FCNT_W'(OFF_FRAMES);
      ST_PAUSE: frame_len = FCNT_W'(PAUSE_FRAMES);
      default:  frame_len = FCNT_W'(ON_FRAMES);
    endcase
  end

  // Counting only runs in timed states, so the first strobe after acceptance is frame one.
  assign fclr = (state_q == ST_IDLE);

  jtframe_led_frmcnt u_frmcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .lvbl_i (LVBL),
    .clr_i  (fclr),
    .len_i  (frame_len),
    .done_o (fdone)
  );

  assign accept = code_valid & code_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      blk_cnt_q    <= '0;
      blk_tgt_q    <= '0;
      rep_cnt_q    <= '0;
      led_out_q    <= ~POL;
      busy_q       <= 1'b0;
      code_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_tgt_q    <= blk_tgt_d;
      rep_cnt_q    <= rep_cnt_d;
      led_out_q    <= led_out_d;
      busy_q       <= busy_d;
      code_ready_q <= code_ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    blk_tgt_d = blk_tgt_q;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (code != 3'd0)) begin
          blk_tgt_d = code;
          blk_cnt_d = '0;
          rep_cnt_d = '0;
          state_d   = ST_ON;
        end
      end
      ST_ON: begin
        if (fdone) begin
          blk_cnt_d = blk_cnt_q + 1'b1;
          state_d   = ST_OFF;
        end
      end
      ST_OFF: begin
        if (fdone) begin
          state_d = (blk_cnt_q == blk_tgt_q) ? ST_PAUSE : ST_ON;
        end
      end
      ST_PAUSE: begin
        if (fdone) begin
          rep_cnt_d = rep_cnt_q + 1'b1;
          blk_cnt_d = '0;
          state_d   = ((int'(rep_cnt_q) + 1) >= REP_N) ? ST_IDLE : ST_ON;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    code_ready_d = (state_d == ST_IDLE);
    led_out_d    = ~POL;
    case (state_q)
      ST_IDLE: led_out_d = (led_in == POL) ? (lit_ok ? POL : ~POL) : led_in;
      ST_ON:   led_out_d = lit_ok ? POL : ~POL;
      default: led_out_d = ~POL;
    endcase
  end

  assign led_out    = led_out_q;
  assign busy       = busy_q;
  assign code_ready = code_ready_q;

endmodule

// File: tb/tb_jtframe_led_pattern.sv
// tb/tb_jtframe_led_pattern.sv - scoreboard bench for the LED blink-code block
// Two instances share clock, reset and LVBL: REPEAT=1 and REPEAT=2.
module tb_jtframe_led_pattern;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lvbl;
  logic       led_in;
  logic [2:0] code1, code2;
  logic       v1, v2;
  logic       cr1, b1, lo1;
  logic       cr2, b2, lo2;

  bit exp1[$];
  bit exp2[$];
  int n_chk  = 0;
  int n_pass = 0;
  int busy1_frames;
  int busy2_frames;

  always #5 clk = ~clk;

  jtframe_led_pattern #(
    .ON_FRAMES(2), .OFF_FRAMES(2), .PAUSE_FRAMES(4), .REPEAT(1), .POL(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .LVBL(lvbl), .led_in(led_in),
    .code(code1), .code_valid(v1),
    .code_ready(cr1), .busy(b1), .led_out(lo1)
  );

  jtframe_led_pattern #(
    .ON_FRAMES(2), .OFF_FRAMES(2), .PAUSE_FRAMES(4), .REPEAT(2), .POL(1'b1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .LVBL(lvbl), .led_in(led_in),
    .code(code2), .code_valid(v2),
    .code_ready(cr2), .busy(b2), .led_out(lo2)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 20-clock frame; the LED level of the frame is sampled just before its falling edge.
  task automatic frame(input int idx);
    bit e;
    lvbl = 1'b1;
    tick(10);
    if (b1) busy1_frames++;
    if (b2) busy2_frames++;
    if (exp1.size() > 0) begin
      e = exp1.pop_front();
      n_chk++;
      if (lo1 !== e) $display("FAIL frame1[%0d] led_out=%b expected=%b", idx, lo1, e);
      else n_pass++;
    end
    if (exp2.size() > 0) begin
      e = exp2.pop_front();
      n_chk++;
      if (lo2 !== e) $display("FAIL frame2[%0d] led_out=%b expected=%b", idx, lo2, e);
      else n_pass++;
    end
    lvbl = 1'b0;
    tick(10);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; lvbl = 1'b1; led_in = 1'b0;
    code1 = '0; code2 = '0; v1 = 1'b0; v2 = 1'b0;
    tick(3);
    n_chk++; if (lo1 !== 1'b0) $display("FAIL reset_led1 got=%b exp=0", lo1); else n_pass++;
    n_chk++; if (lo2 !== 1'b0) $display("FAIL reset_led2 got=%b exp=0", lo2); else n_pass++;
    n_chk++; if (cr1 !== 1'b0) $display("FAIL reset_ready got=%b exp=0", cr1); else n_pass++;
    n_chk++; if (b1 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", b1); else n_pass++;
    rst_n = 1'b1;
    tick(2);
    n_chk++; if (cr1 !== 1'b1) $display("FAIL idle_ready got=%b exp=1", cr1); else n_pass++;
    led_in = 1'b1;
    n_chk++; if (lo1 !== 1'b0) $display("FAIL pass_latency got=%b exp=0", lo1); else n_pass++;
    tick(1);
    n_chk++; if (lo1 !== 1'b1) $display("FAIL pass_through got=%b exp=1", lo1); else n_pass++;
    n_chk++; if (b1 !== 1'b0) $display("FAIL idle_busy got=%b exp=0", b1); else n_pass++;
  endtask

  task automatic test_code_zero;
    led_in = 1'b0;
    code1 = 3'd0; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    n_chk++; if (cr1 !== 1'b1) $display("FAIL zero_ready got=%b exp=1", cr1); else n_pass++;
    n_chk++; if (b1 !== 1'b0) $display("FAIL zero_busy got=%b exp=0", b1); else n_pass++;
    n_chk++; if (lo1 !== 1'b0) $display("FAIL zero_led_low got=%b exp=0", lo1); else n_pass++;
    tick(2);
    n_chk++; if (b1 !== 1'b0) $display("FAIL zero_busy_late got=%b exp=0", b1); else n_pass++;
    led_in = 1'b1;
    tick(1);
    n_chk++; if (lo1 !== 1'b1) $display("FAIL zero_led_high got=%b exp=1", lo1); else n_pass++;
  endtask

  task automatic test_blink3_ignore_busy;
    code1 = 3'd3; v1 = 1'b1;
    tick(1);
    n_chk++; if (b1 !== 1'b1) $display("FAIL b3_busy got=%b exp=1", b1); else n_pass++;
    n_chk++; if (cr1 !== 1'b0) $display("FAIL b3_ready got=%b exp=0", cr1); else n_pass++;
    code1 = 3'd5;
    for (int r = 0; r < 3; r++) begin
      exp1.push_back(1'b1); exp1.push_back(1'b1);
      exp1.push_back(1'b0); exp1.push_back(1'b0);
    end
    for (int p = 0; p < 4; p++) exp1.push_back(1'b0);
    exp1.push_back(1'b1); exp1.push_back(1'b1);
    busy1_frames = 0;
    for (int i = 0; i < 18; i++) begin
      frame(i);
      if (i == 14) v1 = 1'b0;
    end
    n_chk++; if (busy1_frames !== 16) $display("FAIL b3_busy_frames got=%0d exp=16", busy1_frames); else n_pass++;
    n_chk++; if (b1 !== 1'b0) $display("FAIL b3_busy_end got=%b exp=0", b1); else n_pass++;
    n_chk++; if (cr1 !== 1'b1) $display("FAIL b3_ready_end got=%b exp=1", cr1); else n_pass++;
    n_chk++; if (exp1.size() !== 0) $display("FAIL b3_queue left=%0d exp=0", exp1.size()); else n_pass++;
  endtask

  task automatic test_repeat2;
    code2 = 3'd1; v2 = 1'b1;
    tick(1);
    v2 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      exp2.push_back(1'b1); exp2.push_back(1'b1);
      for (int z = 0; z < 6; z++) exp2.push_back(1'b0);
    end
    exp2.push_back(1'b1); exp2.push_back(1'b1);
    busy2_frames = 0;
    for (int i = 0; i < 18; i++) frame(i);
    n_chk++; if (busy2_frames !== 16) $display("FAIL rep2_busy_frames got=%0d exp=16", busy2_frames); else n_pass++;
    n_chk++; if (b2 !== 1'b0) $display("FAIL rep2_busy_end got=%b exp=0", b2); else n_pass++;
    n_chk++; if (exp2.size() !== 0) $display("FAIL rep2_queue left=%0d exp=0", exp2.size()); else n_pass++;
  endtask

  task automatic test_reset_mid;
    code1 = 3'd4; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    exp1.push_back(1'b1); exp1.push_back(1'b1);
    exp1.push_back(1'b0); exp1.push_back(1'b0);
    exp1.push_back(1'b1);
    for (int i = 0; i < 5; i++) frame(i);
    n_chk++; if (lo1 !== 1'b1) $display("FAIL mid_on_led got=%b exp=1", lo1); else n_pass++;
    n_chk++; if (b1 !== 1'b1) $display("FAIL mid_on_busy got=%b exp=1", b1); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (lo1 !== 1'b0) $display("FAIL mid_rst_led got=%b exp=0", lo1); else n_pass++;
    n_chk++; if (b1 !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", b1); else n_pass++;
    n_chk++; if (cr1 !== 1'b0) $display("FAIL mid_rst_ready got=%b exp=0", cr1); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    n_chk++; if (lo1 !== 1'b1) $display("FAIL post_rst_led got=%b exp=1", lo1); else n_pass++;
    n_chk++; if (b1 !== 1'b0) $display("FAIL post_rst_busy got=%b exp=0", b1); else n_pass++;
    n_chk++; if (cr1 !== 1'b1) $display("FAIL post_rst_ready got=%b exp=1", cr1); else n_pass++;
    led_in = 1'b0;
    tick(1);
    n_chk++; if (lo1 !== 1'b0) $display("FAIL post_rst_track got=%b exp=0", lo1); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_code_zero;
    test_blink3_ignore_busy;
    test_repeat2;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
